// File: rtl/univ_shift_engine.sv
// Universal shift register with parallel load, logical/arithmetic/rotate modes,
// multi-bit steps, serial-out capture and an autonomous burst engine.
//
// Ports:
//   clk_i      clock, all state updates on the rising edge
//   rst_ni     asynchronous reset, active-low
//   en_i       single-step enable (honoured only when idle)
//   mode_i     shift mode: 000 HOLD, 001 SHL, 010 SHR, 011 ROL, 100 ROR,
//              101 ASR, 110 SHL0, 111 reserved (HOLD)
//   d_i        serial data in (STEP bits)
//   load_i     parallel load strobe (aborts a running burst)
//   par_in_i   parallel load data
//   start_i    begin a burst of count_i steps
//   count_i    burst length in steps
//   out_o      register contents
//   sout_o     bits that left the register on the last step
//   busy_o     burst in progress
//   done_o     one-cycle pulse when a burst completes
module univ_shift_engine #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned STEP  = 1,
   parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic [2:0]       mode_i,
   input  logic [STEP-1:0]  d_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] par_in_i,
   input  logic             start_i,
   input  logic [CNT_W-1:0] count_i,
   output logic [WIDTH-1:0] out_o,
   output logic [STEP-1:0]  sout_o,
   output logic             busy_o,
   output logic             done_o
);

   localparam logic [2:0] M_SHL  = 3'b001;
   localparam logic [2:0] M_SHR  = 3'b010;
   localparam logic [2:0] M_ROL  = 3'b011;
   localparam logic [2:0] M_ROR  = 3'b100;
   localparam logic [2:0] M_ASR  = 3'b101;
   localparam logic [2:0] M_SHL0 = 3'b110;

   typedef enum logic {ST_IDLE, ST_RUN} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic [STEP-1:0]  sout_q, sout_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       mode_q, mode_d;

   logic [2:0]       sh_mode;
   logic [WIDTH-1:0] sh_val;
   logic [STEP-1:0]  sh_sout;

   // Shift datapath: a burst uses the mode latched at start, otherwise the live mode.
   // HOLD and the reserved code leave both the register and sout untouched.
   always_comb begin
      sh_mode = (state_q == ST_RUN) ? mode_q : mode_i;
      sh_val  = out_q;
      sh_sout = sout_q;
      case (sh_mode)
         M_SHL: begin
            sh_val  = {out_q[WIDTH-STEP-1:0], d_i};
            sh_sout = out_q[WIDTH-1:WIDTH-STEP];
         end
         M_SHR: begin
            sh_val  = {d_i, out_q[WIDTH-1:STEP]};
            sh_sout = out_q[STEP-1:0];
         end
         M_ROL: begin
            sh_val  = {out_q[WIDTH-STEP-1:0], out_q[WIDTH-1:WIDTH-STEP]};
            sh_sout = out_q[WIDTH-1:WIDTH-STEP];
         end
         M_ROR: begin
            sh_val  = {out_q[STEP-1:0], out_q[WIDTH-1:STEP]};
            sh_sout = out_q[STEP-1:0];
         end
         M_ASR: begin
            sh_val  = WIDTH'($signed(out_q) >>> STEP);
            sh_sout = out_q[STEP-1:0];
         end
         M_SHL0: begin
            sh_val  = {out_q[WIDTH-STEP-1:0], STEP'(0)};
            sh_sout = out_q[WIDTH-1:WIDTH-STEP];
         end
         default: ;
      endcase
   end

   // Next-state: load beats start beats en when idle; load aborts a burst silently.
   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      sout_d  = sout_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      case (state_q)
         ST_IDLE: begin
            if (load_i) begin
               out_d = par_in_i;
            end else if (start_i) begin
               if (count_i != '0) begin
                  mode_d  = mode_i;
                  cnt_d   = count_i;
                  busy_d  = 1'b1;
                  state_d = ST_RUN;
               end else begin
                  done_d = 1'b1;
               end
            end else if (en_i) begin
               out_d  = sh_val;
               sout_d = sh_sout;
            end
         end
         ST_RUN: begin
            if (load_i) begin
               out_d   = par_in_i;
               busy_d  = 1'b0;
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               out_d  = sh_val;
               sout_d = sh_sout;
               cnt_d  = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         out_q   <= '0;
         sout_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
         mode_q  <= '0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         sout_q  <= sout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
      end
   end

   assign out_o  = out_q;
   assign sout_o = sout_q;
   assign busy_o = busy_q;
   assign done_o = done_q;

endmodule
